// File: rtl/uart_core_param_if.sv
// uart_core_param_if: TX/RX word handshake bundle between the
// application side (master) and the UART core (slave).
interface uart_core_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;
  logic                 rx_valid;
  logic                 rx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_frame_err;
  logic                 rx_parity_err;
  logic                 rx_overrun;

  modport master (
    output tx_valid, tx_data, rx_ready,
    input  tx_ready, rx_valid, rx_data,
    input  rx_frame_err, rx_parity_err, rx_overrun
  );

  modport slave (
    input  tx_valid, tx_data, rx_ready,
    output tx_ready, rx_valid, rx_data,
    output rx_frame_err, rx_parity_err, rx_overrun
  );
endinterface

// File: rtl/uart_core_param.sv
// uart_core_param: full-duplex UART, fractional baud accumulators per path.
// Define UART_PARITY_EN to add a parity bit on both TX and RX.
module uart_core_param #(
  parameter int BAUD_INC   = 36,
  parameter int BAUD_MOD   = 15625,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FILT_MAX   = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             rst,
  uart_core_param_if.slave bus,
  output logic             txd,
  input  logic             rxd
);
  localparam int ACC_W = $clog2(BAUD_MOD + BAUD_INC);
  localparam int AW1 = ACC_W + 1;
  localparam logic [ACC_W:0] INC = AW1'(BAUD_INC);
  localparam logic [ACC_W:0] MOD = AW1'(BAUD_MOD);
  localparam logic [ACC_W:0] HALF = AW1'(BAUD_MOD / 2);
  localparam logic [ACC_W:0] HEND = AW1'(BAUD_MOD / 2 + BAUD_INC);
  localparam logic [3:0] D_END = 4'(DATA_BITS - 1);
  localparam logic [3:0] SB_END = 4'(STOP_BITS - 1);
  localparam int FW = $clog2(FILT_MAX + 1);
  localparam logic [FW-1:0] F_MAX = FW'(FILT_MAX);
  localparam logic [FW-1:0] F_ONE = FW'(1);
  localparam logic PODD = (PARITY_ODD != 0);
`ifdef UART_PARITY_EN
  localparam logic HAS_PAR = 1'b1;
`else
  localparam logic HAS_PAR = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK
  } state_t;

  state_t               tx_st, tx_nx;
  logic [ACC_W-1:0]     tx_acc;
  logic [ACC_W:0]       tx_sum;
  logic                 tx_tick, tx_go, tx_par;
  logic [DATA_BITS-1:0] tx_sh;
  logic [3:0]           tx_cnt;

  assign tx_sum = {1'b0, tx_acc} + INC;
  assign tx_tick = tx_sum >= MOD;
  assign bus.tx_ready = (tx_st == S_IDLE) && !rst;
  assign tx_go = bus.tx_valid && bus.tx_ready;

  always_comb begin
    tx_nx = tx_st;
    txd = 1'b1;
    unique case (tx_st)
      S_IDLE: if (tx_go) tx_nx = S_START;
      S_START: begin
        txd = 1'b0;
        if (tx_tick) tx_nx = S_DATA;
      end
      S_DATA: begin
        txd = tx_sh[0];
        if (tx_tick && tx_cnt == D_END)
          tx_nx = HAS_PAR ? S_PAR : S_STOP;
      end
      S_PAR: begin
        txd = tx_par;
        if (tx_tick) tx_nx = S_STOP;
      end
      S_STOP: if (tx_tick && tx_cnt == SB_END) tx_nx = S_IDLE;
      default: tx_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st  <= S_IDLE;
      tx_acc <= '0;
      tx_sh  <= '0;
      tx_cnt <= '0;
      tx_par <= 1'b0;
    end else begin
      tx_st <= tx_nx;
      if (tx_st == S_IDLE) begin
        tx_acc <= '0;
        tx_cnt <= '0;
        if (tx_go) begin
          tx_sh  <= bus.tx_data;
          tx_par <= ^bus.tx_data ^ PODD;
        end
      end else begin
        tx_acc <= tx_tick ? ACC_W'(tx_sum - MOD) : ACC_W'(tx_sum);
        if (tx_tick && tx_st == S_DATA) begin
          tx_sh  <= tx_sh >> 1;
          tx_cnt <= (tx_cnt == D_END) ? 4'd0 : tx_cnt + 4'd1;
        end
        if (tx_tick && tx_st == S_STOP) tx_cnt <= tx_cnt + 4'd1;
      end
    end
  end

  state_t               rx_st, rx_nx;
  logic [1:0]           rx_sync;
  logic [FW-1:0]        rx_filt;
  logic                 rx_bit, rx_smp, rx_done, rx_perr;
  logic [ACC_W-1:0]     rx_acc;
  logic [ACC_W:0]       rx_sum;
  logic [DATA_BITS-1:0] rx_sh;
  logic [3:0]           rx_cnt;

  assign rx_sum = {1'b0, rx_acc} + INC;
  assign rx_smp = ({1'b0, rx_acc} >= HALF) && ({1'b0, rx_acc} < HEND);
  assign rx_done = (rx_st == S_STOP) && rx_smp;

  // rx_bit only flips once the filter saturates, absorbing short glitches
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync <= 2'b11;
      rx_filt <= F_MAX;
      rx_bit  <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], rxd};
      if (rx_sync[1] && rx_filt != F_MAX) rx_filt <= rx_filt + F_ONE;
      else if (!rx_sync[1] && rx_filt != '0) rx_filt <= rx_filt - F_ONE;
      if (rx_filt == '0) rx_bit <= 1'b0;
      else if (rx_filt == F_MAX) rx_bit <= 1'b1;
    end
  end

  always_comb begin
    rx_nx = rx_st;
    unique case (rx_st)
      S_IDLE:  if (!rx_bit) rx_nx = S_START;
      S_START: if (rx_smp) rx_nx = rx_bit ? S_IDLE : S_DATA;
      S_DATA:
        if (rx_smp && rx_cnt == D_END)
          rx_nx = HAS_PAR ? S_PAR : S_STOP;
      S_PAR:   if (rx_smp) rx_nx = S_STOP;
      S_STOP:  if (rx_smp) rx_nx = rx_bit ? S_IDLE : S_BREAK;
      S_BREAK: if (rx_bit) rx_nx = S_IDLE;
      default: rx_nx = S_IDLE;
    endcase
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) rx_perr <= 1'b0;
    else if (rx_st == S_PAR && rx_smp)
      rx_perr <= rx_bit ^ (^rx_sh) ^ PODD;
  end
`else
  assign rx_perr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st             <= S_IDLE;
      rx_acc            <= '0;
      rx_sh             <= '0;
      rx_cnt            <= '0;
      bus.rx_valid      <= 1'b0;
      bus.rx_data       <= '0;
      bus.rx_frame_err  <= 1'b0;
      bus.rx_parity_err <= 1'b0;
      bus.rx_overrun    <= 1'b0;
    end else begin
      rx_st          <= rx_nx;
      bus.rx_overrun <= 1'b0;
      if (rx_st == S_IDLE || rx_st == S_BREAK) begin
        rx_acc <= '0;
        rx_cnt <= '0;
      end else begin
        rx_acc <= (rx_sum >= MOD) ? ACC_W'(rx_sum - MOD) : ACC_W'(rx_sum);
      end
      if (rx_smp && rx_st == S_DATA) begin
        rx_sh  <= {rx_bit, rx_sh[DATA_BITS-1:1]};
        rx_cnt <= rx_cnt + 4'd1;
      end
      // a held, unconsumed word wins over a newly completed frame
      if (rx_done) begin
        if (!bus.rx_valid || bus.rx_ready) begin
          bus.rx_valid      <= 1'b1;
          bus.rx_data       <= rx_sh;
          bus.rx_frame_err  <= !rx_bit;
          bus.rx_parity_err <= rx_perr;
        end else begin
          bus.rx_overrun <= 1'b1;
        end
      end else if (bus.rx_valid && bus.rx_ready) begin
        bus.rx_valid <= 1'b0;
      end
    end
  end
endmodule
